// File: rtl/store_queue.sv
// In-order store buffer: allocates at dispatch, collects address/data, commits on
// ROB retirement, drains committed stores to memory and forwards to younger loads.
module store_queue #(
  parameter int SQ_SIZE    = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ROB_SEL    = 6,
  parameter int PTR_W      = $clog2(SQ_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dispatch_store_valid,
  input  logic [ROB_SEL-1:0]    dispatch_rob_idx,
  output logic [PTR_W-1:0]      dispatch_sq_idx,
  output logic [PTR_W:0]        sq_tail_snapshot,
  output logic                  sq_full,
  output logic                  sq_empty,
  input  logic                  addr_valid,
  input  logic [PTR_W-1:0]      addr_sq_idx,
  input  logic [ADDR_WIDTH-1:0] addr_value,
  input  logic                  data_valid,
  input  logic [PTR_W-1:0]      data_sq_idx,
  input  logic [DATA_WIDTH-1:0] data_value,
  input  logic                  commit_valid,
  input  logic [ROB_SEL-1:0]    commit_rob_idx,
  output logic                  commit_mismatch,
  input  logic                  flush,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_data,
  input  logic                  mem_req_ready,
  input  logic                  fwd_req_valid,
  input  logic [ADDR_WIDTH-1:0] fwd_addr,
  input  logic [PTR_W:0]        fwd_sq_tail,
  output logic                  fwd_hit,
  output logic [DATA_WIDTH-1:0] fwd_data,
  output logic                  fwd_stall
);

  localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

  logic [PTR_W:0]        head, cptr, tail, count, cptr_next;
  logic [PTR_W-1:0]      head_i, cptr_i, tail_i;
  logic [SQ_SIZE-1:0]    ent_valid, addr_rdy, data_rdy, committed;
  logic [ROB_SEL-1:0]    rob_q  [SQ_SIZE];
  logic [ADDR_WIDTH-1:0] addr_q [SQ_SIZE];
  logic [DATA_WIDTH-1:0] data_q [SQ_SIZE];
  logic                  commit_ok, drain_fire, dispatch_fire;

  logic [PTR_W:0]        fwd_span;
  logic [PTR_W-1:0]      scan_idx;
  logic                  fwd_done;

  assign head_i = head[PTR_W-1:0];
  assign cptr_i = cptr[PTR_W-1:0];
  assign tail_i = tail[PTR_W-1:0];
  assign count  = tail - head;

  assign sq_empty         = (tail == head);
  assign sq_full          = (tail_i == head_i) && (tail[PTR_W] != head[PTR_W]);
  assign dispatch_sq_idx  = tail_i;
  assign sq_tail_snapshot = tail;

  // cptr == tail means every live entry is already committed
  assign commit_ok     = commit_valid && (cptr != tail) && ent_valid[cptr_i] &&
                         (rob_q[cptr_i] == commit_rob_idx);
  assign cptr_next     = commit_ok ? cptr + PTR_ONE : cptr;
  assign mem_req_valid = ent_valid[head_i] && committed[head_i] &&
                         addr_rdy[head_i] && data_rdy[head_i];
  assign mem_req_addr  = mem_req_valid ? addr_q[head_i] : '0;
  assign mem_req_data  = mem_req_valid ? data_q[head_i] : '0;
  assign drain_fire    = mem_req_valid && mem_req_ready;
  assign dispatch_fire = dispatch_store_valid && !sq_full && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      head            <= '0;
      cptr            <= '0;
      tail            <= '0;
      ent_valid       <= '0;
      addr_rdy        <= '0;
      data_rdy        <= '0;
      committed       <= '0;
      commit_mismatch <= 1'b0;
    end else begin
      commit_mismatch <= commit_valid && !commit_ok;

      if (addr_valid && ent_valid[addr_sq_idx]) begin
        addr_q[addr_sq_idx]   <= addr_value;
        addr_rdy[addr_sq_idx] <= 1'b1;
      end
      if (data_valid && ent_valid[data_sq_idx]) begin
        data_q[data_sq_idx]   <= data_value;
        data_rdy[data_sq_idx] <= 1'b1;
      end

      if (commit_ok) begin
        committed[cptr_i] <= 1'b1;
        cptr              <= cptr_next;
      end

      if (drain_fire) begin
        ent_valid[head_i] <= 1'b0;
        committed[head_i] <= 1'b0;
        head              <= head + PTR_ONE;
      end

      // Uncommitted entries are exactly cptr..tail-1; the one committing now survives
      if (flush) begin
        for (int i = 0; i < SQ_SIZE; i++) begin
          if (ent_valid[i] && !committed[i] && !(commit_ok && (cptr_i == PTR_W'(i))))
            ent_valid[i] <= 1'b0;
        end
        tail <= cptr_next;
      end else if (dispatch_fire) begin
        ent_valid[tail_i] <= 1'b1;
        rob_q[tail_i]     <= dispatch_rob_idx;
        addr_rdy[tail_i]  <= 1'b0;
        data_rdy[tail_i]  <= 1'b0;
        committed[tail_i] <= 1'b0;
        tail              <= tail + PTR_ONE;
      end
    end
  end

  // A snapshot further from head than count refers to drained stores only
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_stall = 1'b0;
    fwd_data  = '0;
    fwd_done  = 1'b0;
    scan_idx  = '0;
    fwd_span  = fwd_sq_tail - head;
    if (fwd_req_valid && (fwd_span <= count)) begin
      for (int k = 0; k < SQ_SIZE; k++) begin
        scan_idx = fwd_sq_tail[PTR_W-1:0] - PTR_W'(k + 1);
        if (!fwd_done && ((PTR_W+1)'(k) < fwd_span) && ent_valid[scan_idx]) begin
          if (!addr_rdy[scan_idx]) begin
            fwd_stall = 1'b1;
            fwd_done  = 1'b1;
          end else if (addr_q[scan_idx] == fwd_addr) begin
            fwd_done = 1'b1;
            if (data_rdy[scan_idx]) begin
              fwd_hit  = 1'b1;
              fwd_data = data_q[scan_idx];
            end else begin
              fwd_stall = 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: a scoreboard queue of expected memory writes is
// filled at commit and drained by a monitor watching the memory handshake.
module tb_store_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        dispatch_store_valid;
  logic [5:0]  dispatch_rob_idx;
  logic [2:0]  dispatch_sq_idx;
  logic [3:0]  sq_tail_snapshot;
  logic        sq_full, sq_empty;
  logic        addr_valid;
  logic [2:0]  addr_sq_idx;
  logic [31:0] addr_value;
  logic        data_valid;
  logic [2:0]  data_sq_idx;
  logic [31:0] data_value;
  logic        commit_valid;
  logic [5:0]  commit_rob_idx;
  logic        commit_mismatch;
  logic        flush;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr, mem_req_data;
  logic        mem_req_ready;
  logic        fwd_req_valid;
  logic [31:0] fwd_addr;
  logic [3:0]  fwd_sq_tail;
  logic        fwd_hit, fwd_stall;
  logic [31:0] fwd_data;

  store_queue #(.SQ_SIZE(8), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ROB_SEL(6)) dut (
    .clk(clk), .reset(reset),
    .dispatch_store_valid(dispatch_store_valid), .dispatch_rob_idx(dispatch_rob_idx),
    .dispatch_sq_idx(dispatch_sq_idx), .sq_tail_snapshot(sq_tail_snapshot),
    .sq_full(sq_full), .sq_empty(sq_empty),
    .addr_valid(addr_valid), .addr_sq_idx(addr_sq_idx), .addr_value(addr_value),
    .data_valid(data_valid), .data_sq_idx(data_sq_idx), .data_value(data_value),
    .commit_valid(commit_valid), .commit_rob_idx(commit_rob_idx),
    .commit_mismatch(commit_mismatch), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready),
    .fwd_req_valid(fwd_req_valid), .fwd_addr(fwd_addr), .fwd_sq_tail(fwd_sq_tail),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } mem_txn_t;

  mem_txn_t expQ[$];
  mem_txn_t monTxn;
  int checkCount = 0;
  int passCount  = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Memory-side monitor: every accepted write must match the oldest committed store
  always @(negedge clk) begin
    if (!reset && mem_req_valid && mem_req_ready) begin
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_drain: got addr 0x%0h, expected no write", mem_req_addr);
      end else begin
        monTxn = expQ.pop_front();
        checkOutput("drain_addr", 64'(mem_req_addr), 64'(monTxn.addr));
        checkOutput("drain_data", 64'(mem_req_data), 64'(monTxn.data));
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    dispatch_store_valid = 1'b0;
    addr_valid           = 1'b0;
    data_valid           = 1'b0;
    commit_valid         = 1'b0;
    flush                = 1'b0;
  endtask

  task automatic doDispatch(input logic [5:0] rob);
    dispatch_store_valid = 1'b1;
    dispatch_rob_idx     = rob;
    cycle();
  endtask

  task automatic doAddrData(input logic [2:0] idx, input logic [31:0] a, input logic [31:0] d);
    addr_valid  = 1'b1;
    addr_sq_idx = idx;
    addr_value  = a;
    data_valid  = 1'b1;
    data_sq_idx = idx;
    data_value  = d;
    cycle();
  endtask

  task automatic doCommit(input logic [5:0] rob, input bit push,
                          input logic [31:0] a, input logic [31:0] d);
    commit_valid   = 1'b1;
    commit_rob_idx = rob;
    if (push) expQ.push_back('{addr: a, data: d});
    cycle();
  endtask

  task automatic fwdCheck(input string name, input logic [3:0] snap, input logic [31:0] a,
                          input logic expHit, input logic expStall, input logic [31:0] expData);
    fwd_req_valid = 1'b1;
    fwd_sq_tail   = snap;
    fwd_addr      = a;
    #1;
    checkOutput({name, "_hit"},   64'(fwd_hit),   64'(expHit));
    checkOutput({name, "_stall"}, 64'(fwd_stall), 64'(expStall));
    checkOutput({name, "_data"},  64'(fwd_data),  64'(expData));
    fwd_req_valid = 1'b0;
  endtask

  task automatic drainAll(input string name);
    mem_req_ready = 1'b1;
    for (int k = 0; k < 20 && !sq_empty; k++) cycle();
    mem_req_ready = 1'b0;
    checkOutput({name, "_empty"}, 64'(sq_empty), 64'h1);
    checkOutput({name, "_scoreboard"}, 64'(expQ.size()), 64'h0);
  endtask

  task automatic applyStimulus();
    // Fill to full, reject the ninth, then retire everything so the tail wraps
    for (int i = 0; i < 8; i++) begin
      checkOutput("dispatch_idx", 64'(dispatch_sq_idx), 64'(i));
      doDispatch(6'(i));
    end
    checkOutput("full_after_8", 64'(sq_full), 64'h1);
    checkOutput("tail_after_8", 64'(sq_tail_snapshot), 64'h8);
    doDispatch(6'd8);
    checkOutput("full_reject_tail", 64'(sq_tail_snapshot), 64'h8);
    checkOutput("full_reject_full", 64'(sq_full), 64'h1);
    for (int i = 0; i < 8; i++) doAddrData(3'(i), 32'h1000 + 32'(4 * i), 32'hA0 + 32'(i));
    for (int i = 0; i < 4; i++) doCommit(6'(i), 1'b1, 32'h1000 + 32'(4 * i), 32'hA0 + 32'(i));
    checkOutput("head_ready_valid", 64'(mem_req_valid), 64'h1);
    checkOutput("head_ready_addr", 64'(mem_req_addr), 64'h1000);
    doCommit(6'd5, 1'b0, 32'h0, 32'h0);
    checkOutput("mismatch_pulse", 64'(commit_mismatch), 64'h1);
    cycle();
    checkOutput("mismatch_clear", 64'(commit_mismatch), 64'h0);
    for (int i = 4; i < 8; i++) doCommit(6'(i), 1'b1, 32'h1000 + 32'(4 * i), 32'hA0 + 32'(i));
    checkOutput("commit_after_mismatch", 64'(commit_mismatch), 64'h0);
    drainAll("drain_eight");
    checkOutput("idx_wrapped", 64'(dispatch_sq_idx), 64'h0);
    checkOutput("tail_wrapped", 64'(sq_tail_snapshot), 64'h8);

    // Single store held by backpressure
    doDispatch(6'd3);
    doAddrData(3'd0, 32'h100, 32'hDEAD);
    doCommit(6'd3, 1'b1, 32'h100, 32'hDEAD);
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall_valid", 64'(mem_req_valid), 64'h1);
      checkOutput("stall_addr", 64'(mem_req_addr), 64'h100);
      checkOutput("stall_data", 64'(mem_req_data), 64'hDEAD);
      cycle();
    end
    mem_req_ready = 1'b1;
    cycle();
    mem_req_ready = 1'b0;
    checkOutput("single_empty", 64'(sq_empty), 64'h1);
    checkOutput("single_valid_low", 64'(mem_req_valid), 64'h0);

    // Forwarding: head=tail=9, entries land at idx 1..4
    doDispatch(6'd10);
    doDispatch(6'd11);
    doAddrData(3'd1, 32'h200, 32'h11);
    doAddrData(3'd2, 32'h200, 32'h22);
    checkOutput("fwd_snapshot", 64'(sq_tail_snapshot), 64'hB);
    fwdCheck("fwd_youngest", 4'hB, 32'h200, 1'b1, 1'b0, 32'h22);
    fwdCheck("fwd_older_snap", 4'hA, 32'h200, 1'b1, 1'b0, 32'h11);
    fwdCheck("fwd_no_match", 4'hB, 32'h300, 1'b0, 1'b0, 32'h0);
    fwdCheck("fwd_no_older", 4'h9, 32'h200, 1'b0, 1'b0, 32'h0);
    dispatch_store_valid = 1'b1;
    dispatch_rob_idx     = 6'd12;
    cycle();
    addr_valid  = 1'b1;
    addr_sq_idx = 3'd3;
    addr_value  = 32'h200;
    cycle();
    fwdCheck("fwd_data_pending", 4'hC, 32'h200, 1'b0, 1'b1, 32'h0);
    dispatch_store_valid = 1'b1;
    dispatch_rob_idx     = 6'd13;
    data_valid           = 1'b1;
    data_sq_idx          = 3'd3;
    data_value           = 32'h33;
    cycle();
    fwdCheck("fwd_unknown_addr", 4'hD, 32'h200, 1'b0, 1'b1, 32'h0);
    fwdCheck("fwd_after_data", 4'hC, 32'h200, 1'b1, 1'b0, 32'h33);
    fwdCheck("fwd_full_width", 4'hC, 32'h80000200, 1'b0, 1'b0, 32'h0);
    flush = 1'b1;
    cycle();
    checkOutput("flush_all_empty", 64'(sq_empty), 64'h1);
    checkOutput("flush_all_tail", 64'(sq_tail_snapshot), 64'h9);

    // Flush with same-cycle dispatch (dropped) and commit (kept)
    for (int i = 0; i < 4; i++) doDispatch(6'(20 + i));
    for (int i = 0; i < 4; i++) doAddrData(3'(1 + i), 32'h300 + 32'(8 * i), 32'h50 + 32'(i));
    doCommit(6'd20, 1'b1, 32'h300, 32'h50);
    flush                = 1'b1;
    dispatch_store_valid = 1'b1;
    dispatch_rob_idx     = 6'd30;
    doCommit(6'd21, 1'b1, 32'h308, 32'h51);
    checkOutput("flush_tail", 64'(sq_tail_snapshot), 64'hB);
    checkOutput("flush_idx", 64'(dispatch_sq_idx), 64'h3);
    checkOutput("flush_commit_ok", 64'(commit_mismatch), 64'h0);
    fwdCheck("fwd_survivor", 4'hB, 32'h308, 1'b1, 1'b0, 32'h51);
    doCommit(6'd22, 1'b0, 32'h0, 32'h0);
    checkOutput("flushed_commit", 64'(commit_mismatch), 64'h1);
    doCommit(6'd30, 1'b0, 32'h0, 32'h0);
    checkOutput("dropped_dispatch", 64'(commit_mismatch), 64'h1);
    drainAll("flush_drain");
    checkOutput("flush_drain_tail", 64'(sq_tail_snapshot), 64'hB);

    // Reset while full with a drainable head
    for (int i = 0; i < 8; i++) doDispatch(6'(40 + i));
    for (int i = 0; i < 8; i++) doAddrData(3'(3 + i), 32'h400 + 32'(i), 32'h60 + 32'(i));
    doCommit(6'd40, 1'b0, 32'h0, 32'h0);
    checkOutput("prereset_valid", 64'(mem_req_valid), 64'h1);
    checkOutput("prereset_full", 64'(sq_full), 64'h1);
    checkOutput("prereset_addr", 64'(mem_req_addr), 64'h400);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checkOutput("postreset_valid", 64'(mem_req_valid), 64'h0);
    checkOutput("postreset_empty", 64'(sq_empty), 64'h1);
    checkOutput("postreset_full", 64'(sq_full), 64'h0);
    checkOutput("postreset_tail", 64'(sq_tail_snapshot), 64'h0);
    checkOutput("postreset_addr", 64'(mem_req_addr), 64'h0);
    doCommit(6'd40, 1'b0, 32'h0, 32'h0);
    checkOutput("postreset_commit", 64'(commit_mismatch), 64'h1);
    doDispatch(6'd50);
    fwdCheck("fwd_new_entry", 4'h1, 32'h400, 1'b0, 1'b1, 32'h0);
  endtask

  initial begin
    reset                = 1'b1;
    dispatch_store_valid = 1'b0;
    dispatch_rob_idx     = '0;
    addr_valid           = 1'b0;
    addr_sq_idx          = '0;
    addr_value           = '0;
    data_valid           = 1'b0;
    data_sq_idx          = '0;
    data_value           = '0;
    commit_valid         = 1'b0;
    commit_rob_idx       = '0;
    flush                = 1'b0;
    mem_req_ready        = 1'b0;
    fwd_req_valid        = 1'b0;
    fwd_addr             = '0;
    fwd_sq_tail          = '0;
    repeat (2) cycle();
    reset = 1'b0;
    checkOutput("reset_empty", 64'(sq_empty), 64'h1);
    checkOutput("reset_full", 64'(sq_full), 64'h0);
    checkOutput("reset_mem_valid", 64'(mem_req_valid), 64'h0);
    checkOutput("reset_mem_addr", 64'(mem_req_addr), 64'h0);
    checkOutput("reset_mem_data", 64'(mem_req_data), 64'h0);
    checkOutput("reset_mismatch", 64'(commit_mismatch), 64'h0);
    checkOutput("reset_tail", 64'(sq_tail_snapshot), 64'h0);
    checkOutput("reset_fwd_hit", 64'(fwd_hit), 64'h0);
    checkOutput("reset_fwd_stall", 64'(fwd_stall), 64'h0);
    applyStimulus();
    cycle();
    checkOutput("final_scoreboard", 64'(expQ.size()), 64'h0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at 200000, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/store_queue.md
Name: store_queue

Overview:
In-order store buffer, the write-side counterpart of the load queue in the LSU.
- Allocates entries at dispatch in program order.
- Captures address and data as they resolve.
- Marks entries committed when the ROB retires the store.
- Drains committed stores to the data memory over a valid/ready port.
- Provides combinational store-to-load forwarding for older stores.

Parameters:
SQ_SIZE, 8, number of entries (power of two, >=2)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, store data width
ROB_SEL, 6, ROB index width
PTR_W, $clog2(SQ_SIZE), entry index width (derived)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
dispatch_store_valid  in  1  allocate entry at tail
dispatch_rob_idx  in  ROB_SEL  ROB index of dispatched store
dispatch_sq_idx  out  PTR_W  index being allocated (tail, combinational)
sq_tail_snapshot  out  PTR_W+1  tail with wrap bit, captured by loads at dispatch
sq_full  out  1  count==SQ_SIZE (combinational)
sq_empty  out  1  count==0 (combinational)
addr_valid  in  1  address update
addr_sq_idx  in  PTR_W  target entry
addr_value  in  ADDR_WIDTH  computed address
data_valid  in  1  data update
data_sq_idx  in  PTR_W  target entry
data_value  in  DATA_WIDTH  store data
commit_valid  in  1  ROB retires a store
commit_rob_idx  in  ROB_SEL  ROB index of retiring store
commit_mismatch  out  1  registered one-cycle pulse: commit ignored
flush  in  1  squash all uncommitted entries
mem_req_valid  out  1  head store ready to write
mem_req_addr  out  ADDR_WIDTH  head address
mem_req_data  out  DATA_WIDTH  head data
mem_req_ready  in  1  memory accepts
fwd_req_valid  in  1  load lookup
fwd_addr  in  ADDR_WIDTH  load address
fwd_sq_tail  in  PTR_W+1  load's captured tail snapshot
fwd_hit  out  1  forward fwd_data
fwd_data  out  DATA_WIDTH  forwarded data
fwd_stall  out  1  load must wait

Behaviour:
- Pointers are PTR_W+1 bits with a wrap bit: head (oldest), cptr (oldest uncommitted), tail. count = tail-head. Per entry: valid, rob_idx, addr, addr_rdy, data, data_rdy, committed.
- Reset: all pointers 0, all valid/rdy/committed bits 0, commit_mismatch 0. Outputs follow: sq_empty=1, sq_full=0, mem_req_valid=0, fwd_hit=0, fwd_stall=0; data outputs 0.
- Dispatch accepted iff dispatch_store_valid && !sq_full, using the pre-edge count. Write entry at tail[PTR_W-1:0] with rdy/committed bits cleared. tail += 1 (wraps naturally).
- Addr/data update: written only if the target entry is valid. Otherwise ignored. Both updates may hit the same entry in one cycle.
- Commit: if commit_valid and the entry at cptr is valid and its rob_idx == commit_rob_idx, set committed and cptr += 1. Otherwise nothing changes and commit_mismatch=1 next cycle.
- Drain: mem_req_valid = head valid && committed && addr_rdy && data_rdy (combinational). mem_req_addr/data come from the head entry. On valid&&ready, head is cleared and head += 1. Outputs are stable while waiting because head is unchanged.
- Flush: tail <= cptr; entries cptr..tail-1 are invalidated. A dispatch in the same cycle is dropped. A commit in the same cycle is applied first, so that entry survives. Drain proceeds normally.
- Simultaneous dispatch + drain: count unchanged. When full, dispatch is still rejected that cycle.
- Forwarding (combinational, valid only when fwd_req_valid, else hit=stall=0):
  - Scan entries from fwd_sq_tail-1 down to head, youngest first, stopping at the first relevant entry.
  - !addr_rdy gives stall.
  - addr==fwd_addr && data_rdy gives hit with that data.
  - addr==fwd_addr && !data_rdy gives stall.
  - No match gives hit=0, stall=0.
  - fwd_sq_tail == head means no older stores.
  - Address match is a full-width exact compare.
  - Drained entries are never searched.

Test Plan:
- Reset, dispatch 8 stores (rob 0..7) -> sq_full=1 after 8th; 9th dispatch ignored, tail unchanged; dispatch_sq_idx wraps 7->0 after drain.
- Store rob 3: addr 0x100, data 0xDEAD, commit rob 3, mem_req_ready=0 for 3 cycles -> mem_req_valid=1 with addr/data stable; ready=1 -> entry freed next cycle, sq_empty=1.
- Commit rob 5 while cptr entry holds rob 4 -> no state change, commit_mismatch pulses 1 cycle.
- Two older stores to 0x200 (data 0x11 then 0x22), load snapshot after both -> fwd_hit=1, fwd_data=0x22. Youngest store's data not ready -> fwd_stall=1. An older store with unknown address younger than the match -> stall.
- 4 stores, first 2 committed, flush with simultaneous dispatch -> tail=cptr=2, dispatch dropped, committed stores still drain in order.
- Reset asserted while mem_req_valid=1 and full -> next cycle mem_req_valid=0, sq_empty=1, all entries invalid.
